// File: rtl/bp_flush_pkg.sv
// Shared types and constants for the branch-predictor flush sequencer.
//   bp_flush_state_e : sequencer FSM state
//   *_INIT           : table initialisation values written during a clear
//   max_rows()       : largest row count among the four tables
package bp_flush_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StClear
    } bp_flush_state_e;

    // Choice counters start weakly preferring the global predictor.
    localparam logic [1:0] MBP_INIT = 2'b10;
    // Direction counters start weakly not-taken.
    localparam logic [1:0] GBP_INIT = 2'b01;
    localparam logic [1:0] LBP_INIT = 2'b01;
    localparam logic       LHR_INIT_BIT = 1'b0;

    function automatic int unsigned max_rows(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   : clock
//   clr_i   : synchronous clear to zero (takes priority over inc_i)
//   inc_i   : increment by one unless already at all-ones
//   count_o : current count
module bp_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/bp_flush_sequencer.sv
// Branch-predictor table clear sequencer. Walks every row of the choice (MBP), global (GBP),
// local (LBP) counter banks and local history table (LHR) after reset and on each flush,
// owning the RAM write ports while clearing and gating predictions/updates until done.
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   flush_bp_i              : flush request (pulse or level)
//   debug_mode_i            : defers the start of a clear while high
//   update_valid_i          : resolved-branch update offered
//   update_accept_o         : update taken (dropped while busy)
//   busy_o, pred_gate_o     : clear in progress or pending
//   row_o                   : row being written
//   *_we_o                  : per-bank write enables, *_wdata_o : init values
//   flush_cnt_o, drop_cnt_o : statistics, present only with BP_FLUSH_STATS_EN defined
module bp_flush_sequencer
    import bp_flush_pkg::*;
#(
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned MBP_ROWS        = 256,
    parameter int unsigned GBP_ROWS        = 256,
    parameter int unsigned LBP_ROWS        = 256,
    parameter int unsigned LHR_ROWS        = 64,
    parameter int unsigned LHR_BITS        = 8,
    localparam int unsigned MaxRows = max_rows(MBP_ROWS, GBP_ROWS, LBP_ROWS, LHR_ROWS),
    localparam int unsigned RowW    = (MaxRows > 1) ? $clog2(MaxRows) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_bp_i,
    input  logic                       debug_mode_i,
    input  logic                       update_valid_i,
    output logic                       update_accept_o,
    output logic                       busy_o,
    output logic                       pred_gate_o,
    output logic [RowW-1:0]            row_o,
    output logic [INSTR_PER_FETCH-1:0] mbp_we_o,
    output logic [INSTR_PER_FETCH-1:0] gbp_we_o,
    output logic [INSTR_PER_FETCH-1:0] lbp_we_o,
    output logic [INSTR_PER_FETCH-1:0] lhr_we_o,
    output logic [1:0]                 mbp_wdata_o,
    output logic [1:0]                 gbp_wdata_o,
    output logic [1:0]                 lbp_wdata_o,
`ifdef BP_FLUSH_STATS_EN
    output logic [15:0]                flush_cnt_o,
    output logic [15:0]                drop_cnt_o,
`endif
    output logic [LHR_BITS-1:0]        lhr_wdata_o
);

    localparam logic [RowW-1:0] LastRow = RowW'(MaxRows - 1);

    bp_flush_state_e state_q, state_d;
    logic [RowW-1:0] row_q, row_d;
    logic [31:0]     row_ext;
    logic            clearing;
    logic            busy;

    // State register: reset lands directly in StClear so release starts the power-on clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StClear;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle: begin
                if (flush_bp_i) begin
                    row_d   = '0;
                    state_d = debug_mode_i ? StPend : StClear;
                end
            end
            StPend: begin
                // Extra flushes are absorbed: a clear is already owed.
                if (!debug_mode_i) begin
                    state_d = StClear;
                    row_d   = '0;
                end
            end
            StClear: begin
                // Debug mode does not pause a clear already running.
                if (flush_bp_i) begin
                    row_d = '0;
                end else if (row_q == LastRow) begin
                    state_d = StIdle;
                    row_d   = '0;
                end else begin
                    row_d = row_q + RowW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                row_d   = '0;
            end
        endcase
    end

    assign row_ext  = 32'(row_q);
    // Writes are suppressed while reset is held even though state_q already reads StClear.
    assign clearing = (state_q == StClear) && !rst_i;
    assign busy     = rst_i || (state_q != StIdle);

    // Output logic.
    always_comb begin
        mbp_we_o        = '0;
        gbp_we_o        = '0;
        lbp_we_o        = '0;
        lhr_we_o        = '0;
        if (clearing && (row_ext < MBP_ROWS)) mbp_we_o = '1;
        if (clearing && (row_ext < GBP_ROWS)) gbp_we_o = '1;
        if (clearing && (row_ext < LBP_ROWS)) lbp_we_o = '1;
        if (clearing && (row_ext < LHR_ROWS)) lhr_we_o = '1;
        busy_o          = busy;
        pred_gate_o     = busy;
        update_accept_o = update_valid_i && !busy;
    end

    assign row_o       = row_q;
    assign mbp_wdata_o = MBP_INIT;
    assign gbp_wdata_o = GBP_INIT;
    assign lbp_wdata_o = LBP_INIT;
    assign lhr_wdata_o = {LHR_BITS{LHR_INIT_BIT}};

`ifdef BP_FLUSH_STATS_EN
    logic clear_start;
    logic drop;

    // A clear starts on every cycle that writes row 0, covering power-on, flush and restart.
    assign clear_start = clearing && (row_q == '0);
    assign drop        = update_valid_i && busy && !rst_i;

    bp_sat_counter #(
        .Width(16)
    ) u_flush_cnt (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .inc_i  (clear_start),
        .count_o(flush_cnt_o)
    );

    bp_sat_counter #(
        .Width(16)
    ) u_drop_cnt (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .inc_i  (drop),
        .count_o(drop_cnt_o)
    );
`endif

endmodule
